// File: rtl/seq_alu.sv
// seq_alu: clocked ALU with start/ready/valid handshake; signed MUL/DIV run on a radix-2 engine.
// MUL/DIV iterate on operand magnitudes and apply the sign in FIX.
module seq_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock_i,
    input  logic               reset_n_i,
    input  logic               start_i,
    input  logic [4:0]         opcode_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               zero_o,
    output logic               negative_o,
    output logic               div_by_zero_o,
    output logic               illegal_op_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101,
                           OP_SHRA = 5'b00110, OP_SHL  = 5'b00111, OP_ROR  = 5'b01000,
                           OP_ROL  = 5'b01001, OP_AND  = 5'b01010, OP_OR   = 5'b01011,
                           OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110,
                           OP_MUL  = 5'b01111, OP_DIV  = 5'b10000, OP_NEG  = 5'b10001,
                           OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, FIX} state_t;

    state_t             state_q;
    logic [4:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q, m_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] res_q;
    logic               valid_q, zero_q, neg_q, dbz_q, ill_q;

    logic [WIDTH-1:0]   mag_a_d, mag_b_d, hi_d, lo_d, dif_d;
    logic [WIDTH:0]     sum_d, shl_d;
    logic               fit_d, iter_d, sgn_d, legal_d, wide_d;
    logic [SHAMT_W-1:0] sh_d;
    logic [2*WIDTH-1:0] ror_d, rol_d, exe_d, prod_d, fix_d, out_d;

    assign mag_a_d = a_i[WIDTH-1] ? -a_i : a_i;
    assign mag_b_d = b_i[WIDTH-1] ? -b_i : b_i;
    assign iter_d  = (opcode_i == OP_MUL) || (opcode_i == OP_DIV && b_i != '0);

    // One step: MUL shifts the product right after a conditional add, DIV restores.
    always_comb begin
        sum_d = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shl_d = {hi_q, lo_q[WIDTH-1]};
        dif_d = shl_d[WIDTH-1:0] - m_q;
        fit_d = shl_d >= {1'b0, m_q};
        hi_d  = (op_q == OP_DIV) ? (fit_d ? dif_d : shl_d[WIDTH-1:0]) : sum_d[WIDTH:1];
        lo_d  = (op_q == OP_DIV) ? {lo_q[WIDTH-2:0], fit_d} : {sum_d[0], lo_q[WIDTH-1:1]};
    end

    always_comb begin
        sh_d  = b_q[SHAMT_W-1:0];
        ror_d = {a_q, a_q} >> sh_d;
        rol_d = {a_q, a_q} << sh_d;
        exe_d = '0;
        case (op_q)
            OP_ADD, OP_ADDI: exe_d[WIDTH-1:0] = a_q + b_q;
            OP_SUB:          exe_d[WIDTH-1:0] = a_q - b_q;
            OP_SHR:          exe_d[WIDTH-1:0] = a_q >> sh_d;
            OP_SHRA:         exe_d[WIDTH-1:0] = $signed(a_q) >>> sh_d;
            OP_SHL:          exe_d[WIDTH-1:0] = a_q << sh_d;
            OP_ROR:          exe_d[WIDTH-1:0] = ror_d[WIDTH-1:0];
            OP_ROL:          exe_d[WIDTH-1:0] = rol_d[2*WIDTH-1:WIDTH];
            OP_AND, OP_ANDI: exe_d[WIDTH-1:0] = a_q & b_q;
            OP_OR, OP_ORI:   exe_d[WIDTH-1:0] = a_q | b_q;
            OP_NEG:          exe_d[WIDTH-1:0] = -b_q;
            OP_NOT:          exe_d[WIDTH-1:0] = ~b_q;
            OP_DIV:          exe_d = {a_q, {WIDTH{1'b1}}};
            default:         exe_d = '0;
        endcase
    end

    always_comb begin
        sgn_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        prod_d  = {hi_q, lo_q};
        fix_d   = (op_q == OP_DIV) ? {(a_q[WIDTH-1] ? -hi_q : hi_q), (sgn_d ? -lo_q : lo_q)}
                                   : (sgn_d ? -prod_d : prod_d);
        out_d   = (state_q == FIX) ? fix_d : exe_d;
        wide_d  = op_q == OP_MUL;
        legal_d = op_q inside {OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL, OP_AND,
                               OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_MUL, OP_DIV, OP_NEG, OP_NOT};
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            dbz_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    op_q    <= opcode_i;
                    a_q     <= a_i;
                    b_q     <= b_i;
                    hi_q    <= '0;
                    lo_q    <= mag_a_d;
                    m_q     <= mag_b_d;
                    cnt_q   <= CNT_W'(WIDTH);
                    state_q <= iter_d ? ITER : EXEC;
                end
                ITER: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    cnt_q   <= cnt_q - 1'b1;
                    state_q <= (cnt_q == CNT_W'(1)) ? FIX : ITER;
                end
                default: begin
                    res_q   <= out_d;
                    zero_q  <= wide_d ? (out_d == '0) : (out_d[WIDTH-1:0] == '0);
                    neg_q   <= wide_d ? out_d[2*WIDTH-1] : out_d[WIDTH-1];
                    dbz_q   <= (state_q == EXEC) && (op_q == OP_DIV);
                    ill_q   <= !legal_d;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o       = state_q == IDLE;
    assign valid_o       = valid_q;
    assign result_o      = res_q;
    assign zero_o        = zero_q;
    assign negative_o    = neg_q;
    assign div_by_zero_o = dbz_q;
    assign illegal_op_o  = ill_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8.
module tb_seq_alu;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_SHR  = 5'b00101,
                           OP_SHRA = 5'b00110, OP_SHL  = 5'b00111, OP_ROR  = 5'b01000,
                           OP_ROL  = 5'b01001, OP_AND  = 5'b01010, OP_OR   = 5'b01011,
                           OP_ADDI = 5'b01100, OP_ORI  = 5'b01110, OP_MUL  = 5'b01111,
                           OP_DIV  = 5'b10000, OP_NEG  = 5'b10001, OP_NOT  = 5'b10010;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic [3:0]  flags;
        int          lat;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        st32, st8, rdy32, rdy8, val32, val8;
    logic [4:0]  op32, op8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [63:0] r32;
    logic [15:0] r8;
    logic        z32, n32, d32, i32, z8, n8, d8, i8;

    int   n_chk = 0, n_err = 0, cyc = 0, acc32 = 0, acc8 = 0;
    bit   busy32 = 0, busy8 = 0, seen32 = 0, seen8 = 0;
    exp_t q32[$], q8[$];

    seq_alu #(.WIDTH(32)) dut32 (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(st32), .opcode_i(op32), .a_i(a32), .b_i(b32),
        .ready_o(rdy32), .valid_o(val32), .result_o(r32), .zero_o(z32), .negative_o(n32),
        .div_by_zero_o(d32), .illegal_op_o(i32)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(st8), .opcode_i(op8), .a_i(a8), .b_i(b8),
        .ready_o(rdy8), .valid_o(val8), .result_o(r8), .zero_o(z8), .negative_o(n8),
        .div_by_zero_o(d8), .illegal_op_o(i8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input int w, input logic [4:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input string tag);
        exp_t        e;
        logic [63:0] mk, m2, ua, ub, r;
        longint      sa, sb, t;
        int          sh;
        logic        wide, dbz, ill, zero, neg;
        mk = (64'd1 << w) - 64'd1;
        m2 = (w == 32) ? '1 : (64'd1 << (2 * w)) - 64'd1;
        ua = {32'd0, a} & mk;
        ub = {32'd0, b} & mk;
        sa = longint'(ua) <<< (64 - w);
        sa = sa >>> (64 - w);
        sb = longint'(ub) <<< (64 - w);
        sb = sb >>> (64 - w);
        sh = int'(ub) & (w - 1);
        wide = 0; dbz = 0; ill = 0; r = '0;
        case (op)
            OP_ADD, OP_ADDI: r = (ua + ub) & mk;
            OP_SUB:          r = (ua - ub) & mk;
            OP_SHR:          r = ua >> sh;
            OP_SHRA:         begin t = sa >>> sh; r = 64'(t) & mk; end
            OP_SHL:          r = (ua << sh) & mk;
            OP_ROR:          r = ((ua >> sh) | (ua << (w - sh))) & mk;
            OP_ROL:          r = ((ua << sh) | (ua >> (w - sh))) & mk;
            OP_AND, 5'b01101: r = ua & ub;
            OP_OR, OP_ORI:   r = ua | ub;
            OP_NEG:          r = (64'd0 - ub) & mk;
            OP_NOT:          r = ~ub & mk;
            OP_MUL:          begin t = sa * sb; r = 64'(t) & m2; wide = 1; end
            OP_DIV: begin
                if (ub == 64'd0) begin
                    r = (ua << w) | mk;
                    dbz = 1;
                end else begin
                    t = sa / sb;
                    r = 64'(t) & mk;
                    t = sa % sb;
                    r = r | ((64'(t) & mk) << w);
                end
            end
            default:         ill = 1;
        endcase
        zero = wide ? (r == 64'd0) : ((r & mk) == 64'd0);
        neg  = wide ? r[2*w-1] : r[w-1];
        e.tag   = tag;
        e.res   = r;
        e.flags = {zero, neg, dbz, ill};
        e.lat   = (wide || (op == OP_DIV && ub != 64'd0)) ? w + 2 : 2;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (val32) begin
            if (q32.size() == 0) check("unexpected_valid32", 64'(val32), 64'd0);
            else begin
                e = q32.pop_front();
                check({e.tag, "_res"}, r32, e.res);
                check({e.tag, "_flags"}, 64'({z32, n32, d32, i32}), 64'(e.flags));
                check({e.tag, "_lat"}, 64'(cyc - acc32 + 1), 64'(e.lat));
                check({e.tag, "_busy"}, 64'(seen32), 64'd0);
            end
            busy32 = 0;
        end else if (busy32 && rdy32) seen32 = 1;
        if (st32 && rdy32 && rst_n) begin acc32 = cyc + 1; busy32 = 1; seen32 = 0; end
    end

    always @(negedge clk) begin
        exp_t e;
        if (val8) begin
            if (q8.size() == 0) check("unexpected_valid8", 64'(val8), 64'd0);
            else begin
                e = q8.pop_front();
                check({e.tag, "_res"}, 64'(r8), e.res);
                check({e.tag, "_flags"}, 64'({z8, n8, d8, i8}), 64'(e.flags));
                check({e.tag, "_lat"}, 64'(cyc - acc8 + 1), 64'(e.lat));
                check({e.tag, "_busy"}, 64'(seen8), 64'd0);
            end
            busy8 = 0;
        end else if (busy8 && rdy8) seen8 = 1;
        if (st8 && rdy8 && rst_n) begin acc8 = cyc + 1; busy8 = 1; seen8 = 0; end
    end

    task automatic issue(input bit w8, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input string tag);
        int n = 0;
        while (!(w8 ? rdy8 : rdy32) && n < 100) begin @(posedge clk); #2; n++; end
        check({tag, "_ready"}, 64'(w8 ? rdy8 : rdy32), 64'd1);
        if (w8) begin
            st8 = 1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
            q8.push_back(model(8, op, a, b, tag));
        end else begin
            st32 = 1; op32 = op; a32 = a; b32 = b;
            q32.push_back(model(32, op, a, b, tag));
        end
        @(posedge clk); #2;
        if (w8) begin st8 = 0; op8 = 5'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); end
        else begin st32 = 0; op32 = 5'($urandom); a32 = $urandom; b32 = $urandom; end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((q32.size() + q8.size()) != 0 && n < 300) begin @(posedge clk); #2; n++; end
        check({tag, "_drain"}, 64'(q32.size() + q8.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        st32 = 0; st8 = 0; op32 = '0; op8 = '0; a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ready", 64'(rdy32), 64'd1);
        check("rst_outs", {63'd0, val32} | r32 | 64'({z32, n32, d32, i32}), 64'd0);
        check("rst_ready8", 64'(rdy8), 64'd1);
        rst_n = 1;
        @(posedge clk); #2;
        issue(0, OP_SUB, 32'd3, 32'd5, "sub_3_5");
        drain("sub");
        issue(0, OP_MUL, 32'h1234_5678, 32'h0000_0F0F, "mul_rst");
        repeat (10) @(posedge clk);
        #1 rst_n = 0;
        #1;
        q32.delete();
        busy32 = 0;
        check("rstmid_ready", 64'(rdy32), 64'd1);
        check("rstmid_valid", 64'(val32), 64'd0);
        check("rstmid_result", r32, 64'd0);
        check("rstmid_flags", 64'({z32, n32, d32, i32}), 64'd0);
        @(posedge clk); #2 rst_n = 1;
        @(posedge clk); #2;
        issue(0, OP_ADD,  32'd5, 32'd7, "add_5_7");
        issue(0, OP_SHRA, 32'h8000_0000, 32'd4, "shra");
        issue(0, OP_ROL,  32'h8000_0001, 32'd1, "rol");
        issue(0, OP_NOT,  32'h1234_5678, 32'd0, "not_0");
        issue(0, 5'b11111, 32'd9, 32'd9, "illegal_1f");
        issue(0, OP_SHR,  32'h8000_0000, 32'h0000_001F, "shr_31");
        issue(0, OP_SHL,  32'hDEAD_BEEF, 32'h0000_0020, "shl_amt0");
        issue(0, OP_ROR,  32'h0000_0001, 32'd4, "ror_4");
        issue(0, OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, "and");
        issue(0, OP_ORI,  32'h0000_00F0, 32'h0000_000F, "ori");
        issue(0, OP_NEG,  32'd0, 32'd1, "neg_1");
        issue(0, OP_ADDI, 32'hFFFF_FFFF, 32'd1, "addi_wrap");
        issue(0, OP_SUB,  32'd5, 32'd5, "sub_zero");
        drain("single");
        issue(0, OP_MUL,  -32'sd3, 32'd7, "mul_m3_7");
        issue(0, OP_MUL,  32'h7FFF_FFFF, 32'h7FFF_FFFF, "mul_max_sq");
        issue(0, OP_MUL,  32'd0, 32'hFFFF_FFFF, "mul_zero");
        issue(0, OP_DIV,  -32'sd7, 32'd2, "div_m7_2");
        issue(0, OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        issue(0, OP_DIV,  32'd9, 32'd0, "div_9_0");
        issue(0, OP_ADD,  32'd1, 32'd2, "add_clear");
        issue(0, 5'b00000, 32'd1, 32'd2, "illegal_00");
        issue(0, OP_DIV,  32'd7, -32'sd2, "div_7_m2");
        drain("muldiv");
        issue(0, OP_DIV,  32'd1000, -32'sd7, "div_ignore");
        repeat (5) @(posedge clk);
        #2 st32 = 1; op32 = OP_ADD; a32 = 32'd1; b32 = 32'd1;
        @(posedge clk); #2 st32 = 0;
        drain("ignore");
        st32 = 1; op32 = OP_AND; a32 = 32'hF0F0_1234; b32 = 32'h0FF0_FF00;
        q32.push_back(model(32, OP_AND, a32, b32, "and_hold"));
        @(posedge clk); #2;
        op32 = OP_OR; a32 = 32'h0000_1111; b32 = 32'h2222_0000;
        q32.push_back(model(32, OP_OR, a32, b32, "or_hold"));
        @(posedge clk); #2;
        check("hold_valid", 64'(val32), 64'd1);
        check("hold_ready", 64'(rdy32), 64'd1);
        @(posedge clk); #2;
        check("hold_reaccept", 64'(rdy32), 64'd0);
        st32 = 0;
        drain("hold");
        issue(1, OP_MUL, 32'h80, 32'h80, "mul8_min_sq");
        issue(1, OP_SHL, 32'h01, 32'h0F, "shl8_7");
        issue(1, OP_DIV, 32'd100, 32'd7, "div8_100_7");
        issue(1, OP_DIV, 32'h80, 32'hFF, "div8_min_m1");
        issue(1, OP_DIV, 32'h05, 32'h00, "div8_by0");
        issue(1, OP_ROR, 32'h81, 32'h01, "ror8");
        drain("w8");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
